band_playback_mux: RTL and testbench

Multi-channel audio sample playback engine. It time-multiplexes one synchronous-read sample memory port across NUM_CH band channels and fetches one sample per channel on every audio-rate enable strobe. Each channel has independent start/stop control and a loop or one-shot mode. It sits between the band sample memories (concatenated into one memory, one CH_DEPTH region per channel) and the mixer, which consumes the registered per-channel samples on valid_out.

---
 rtl/band_playback_mux.sv | 229 ++++++++++++++++++++++
 tb/tb_band_playback_mux.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/band_playback_mux.sv
// Multi-channel sample playback engine: one shared synchronous-read memory port is
// time-multiplexed across NUM_CH channels, one sample per channel per enable strobe.
module band_playback_mux #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 16,
    parameter int CH_DEPTH   = 4036,
    parameter int MEM_ADDR_W = $clog2(NUM_CH * CH_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH-1:0]        stop,
    input  logic [NUM_CH-1:0]        loop_mode,
    output logic [MEM_ADDR_W-1:0]    mem_addr,
    output logic                     mem_en,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     valid_out,
    output logic [NUM_CH-1:0]        playing,
    output logic [NUM_CH-1:0]        done,
    output logic                     overrun
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (CH_DEPTH > 1) ? $clog2(CH_DEPTH) : 1;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CH_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    function automatic logic [MEM_ADDR_W-1:0] slot_addr(input logic [CH_W-1:0] ch,
                                                        input logic [PTR_W-1:0] ptr);
        return MEM_ADDR_W'(32'(ch) * CH_DEPTH) + MEM_ADDR_W'(ptr);
    endfunction

    state_t                          state_r, state_next_s;
    logic [CH_W-1:0]                 ch_idx_r, ch_idx_next_s, nxt_ch_s;
    logic [NUM_CH-1:0][PTR_W-1:0]    ptr_r, ptr_next_s;
    logic [NUM_CH-1:0]               playing_r, playing_next_s;
    logic [NUM_CH-1:0]               loop_r, loop_next_s;
    logic [NUM_CH-1:0]               pend_start_r, pend_start_next_s;
    logic [NUM_CH-1:0]               pend_stop_r, pend_stop_next_s;
    logic [NUM_CH-1:0]               eff_start_s, eff_stop_s;
    logic [NUM_CH*DATA_W-1:0]        shadow_r, shadow_next_s;
    logic [NUM_CH-1:0]               done_pend_r, done_pend_next_s;
    logic [MEM_ADDR_W-1:0]           mem_addr_r, mem_addr_next_s;
    logic                            mem_en_r, mem_en_next_s;
    logic [NUM_CH*DATA_W-1:0]        data_out_r, data_out_next_s;
    logic                            valid_r, valid_next_s;
    logic [NUM_CH-1:0]               done_r, done_next_s;
    logic                            overrun_r, overrun_next_s;
    logic                            cap_valid_s;
    logic [CH_W-1:0]                 cap_ch_s;
    logic [DATA_W-1:0]               cap_data_s;

    assign mem_addr  = mem_addr_r;
    assign mem_en    = mem_en_r;
    assign data_out  = data_out_r;
    assign valid_out = valid_r;
    assign playing   = playing_r;
    assign done      = done_r;
    assign overrun   = overrun_r;

    // Select which channel's read data is on mem_rdata this cycle (one cycle behind its address).
    always_comb begin
        cap_valid_s = 1'b0;
        cap_ch_s    = {CH_W{1'b0}};
        case (state_r)
            ST_FETCH: begin
                cap_valid_s = (ch_idx_r != {CH_W{1'b0}});
                cap_ch_s    = ch_idx_r - CH_W'(1);
            end
            ST_DRAIN: begin
                cap_valid_s = 1'b1;
                cap_ch_s    = LAST_CH;
            end
            default: begin
                cap_valid_s = 1'b0;
                cap_ch_s    = {CH_W{1'b0}};
            end
        endcase
        cap_data_s = playing_r[cap_ch_s] ? mem_rdata : {DATA_W{1'b0}};
        nxt_ch_s   = ch_idx_r + CH_W'(1);
    end

    // Next-state, command merge, capture/pointer advance and registered-output values.
    always_comb begin
        state_next_s      = state_r;
        ch_idx_next_s     = ch_idx_r;
        ptr_next_s        = ptr_r;
        playing_next_s    = playing_r;
        loop_next_s       = loop_r;
        shadow_next_s     = shadow_r;
        done_pend_next_s  = done_pend_r;
        mem_addr_next_s   = mem_addr_r;
        mem_en_next_s     = 1'b0;
        data_out_next_s   = data_out_r;
        valid_next_s      = 1'b0;
        done_next_s       = {NUM_CH{1'b0}};
        overrun_next_s    = overrun_r | (enable & (state_r != ST_IDLE));

        // A stop always beats a start; any new command replaces the pending one.
        eff_stop_s        = stop | (pend_stop_r & ~start);
        eff_start_s       = (start | pend_start_r) & ~stop;
        pend_start_next_s = eff_start_s;
        pend_stop_next_s  = eff_stop_s;

        if (cap_valid_s) begin
            shadow_next_s[int'(cap_ch_s)*DATA_W +: DATA_W] = cap_data_s;
            if (playing_r[cap_ch_s]) begin
                if (ptr_r[cap_ch_s] == LAST_PTR) begin
                    ptr_next_s[cap_ch_s] = {PTR_W{1'b0}};
                    if (!loop_r[cap_ch_s]) begin
                        playing_next_s[cap_ch_s]   = 1'b0;
                        done_pend_next_s[cap_ch_s] = 1'b1;
                    end else begin
                        playing_next_s[cap_ch_s]   = playing_r[cap_ch_s];
                    end
                end else begin
                    ptr_next_s[cap_ch_s] = ptr_r[cap_ch_s] + PTR_W'(1);
                end
            end else begin
                ptr_next_s[cap_ch_s] = ptr_r[cap_ch_s];
            end
        end else begin
            shadow_next_s = shadow_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_next_s      = ST_FETCH;
                    ch_idx_next_s     = {CH_W{1'b0}};
                    loop_next_s       = loop_mode;
                    done_pend_next_s  = {NUM_CH{1'b0}};
                    pend_start_next_s = {NUM_CH{1'b0}};
                    pend_stop_next_s  = {NUM_CH{1'b0}};
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (eff_stop_s[k]) begin
                            playing_next_s[k] = 1'b0;
                            ptr_next_s[k]     = {PTR_W{1'b0}};
                        end else if (eff_start_s[k]) begin
                            playing_next_s[k] = 1'b1;
                            ptr_next_s[k]     = {PTR_W{1'b0}};
                        end else begin
                            playing_next_s[k] = playing_r[k];
                        end
                    end
                    mem_addr_next_s = slot_addr({CH_W{1'b0}}, ptr_next_s[0]);
                    mem_en_next_s   = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (ch_idx_r == LAST_CH) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    ch_idx_next_s   = nxt_ch_s;
                    mem_addr_next_s = slot_addr(nxt_ch_s, ptr_r[nxt_ch_s]);
                    mem_en_next_s   = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_next_s    = ST_PUBLISH;
                data_out_next_s = shadow_next_s;
                valid_next_s    = 1'b1;
                done_next_s     = done_pend_next_s;
            end
            ST_PUBLISH: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath, channel status and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_idx_r     <= {CH_W{1'b0}};
            ptr_r        <= {(NUM_CH*PTR_W){1'b0}};
            playing_r    <= {NUM_CH{1'b0}};
            loop_r       <= {NUM_CH{1'b0}};
            pend_start_r <= {NUM_CH{1'b0}};
            pend_stop_r  <= {NUM_CH{1'b0}};
            shadow_r     <= {(NUM_CH*DATA_W){1'b0}};
            done_pend_r  <= {NUM_CH{1'b0}};
            mem_addr_r   <= {MEM_ADDR_W{1'b0}};
            mem_en_r     <= 1'b0;
            data_out_r   <= {(NUM_CH*DATA_W){1'b0}};
            valid_r      <= 1'b0;
            done_r       <= {NUM_CH{1'b0}};
            overrun_r    <= 1'b0;
        end else begin
            ch_idx_r     <= ch_idx_next_s;
            ptr_r        <= ptr_next_s;
            playing_r    <= playing_next_s;
            loop_r       <= loop_next_s;
            pend_start_r <= pend_start_next_s;
            pend_stop_r  <= pend_stop_next_s;
            shadow_r     <= shadow_next_s;
            done_pend_r  <= done_pend_next_s;
            mem_addr_r   <= mem_addr_next_s;
            mem_en_r     <= mem_en_next_s;
            data_out_r   <= data_out_next_s;
            valid_r      <= valid_next_s;
            done_r       <= done_next_s;
            overrun_r    <= overrun_next_s;
        end
    end

endmodule

// File: tb/tb_band_playback_mux.sv
// Bench for band_playback_mux: a full-size instance for address/overrun timing and a
// CH_DEPTH=8 instance for loop, one-shot, restart and signed-data behaviour.
module tb_band_playback_mux;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int DEP_A = 4036;
    localparam int DEP_B = 8;
    localparam int AW_A  = $clog2(NCH * DEP_A);
    localparam int AW_B  = $clog2(NCH * DEP_B);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic                en_a, en_b;
    logic [NCH-1:0]      start_a, stop_a, loop_a, start_b, stop_b, loop_b;
    logic [AW_A-1:0]     addr_a;
    logic [AW_B-1:0]     addr_b;
    logic                men_a, men_b, valid_a, valid_b, ovr_a, ovr_b;
    logic [DW-1:0]       rdata_a, rdata_b;
    logic [NCH*DW-1:0]   dout_a, dout_b;
    logic [NCH-1:0]      playing_a, playing_b, done_a, done_b;
    logic [DW-1:0]       mem_b [NCH*DEP_B];

    band_playback_mux #(.NUM_CH(NCH), .DATA_W(DW), .CH_DEPTH(DEP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .start(start_a), .stop(stop_a),
        .loop_mode(loop_a), .mem_addr(addr_a), .mem_en(men_a), .mem_rdata(rdata_a),
        .data_out(dout_a), .valid_out(valid_a), .playing(playing_a), .done(done_a),
        .overrun(ovr_a));

    band_playback_mux #(.NUM_CH(NCH), .DATA_W(DW), .CH_DEPTH(DEP_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .start(start_b), .stop(stop_b),
        .loop_mode(loop_b), .mem_addr(addr_b), .mem_en(men_b), .mem_rdata(rdata_b),
        .data_out(dout_b), .valid_out(valid_b), .playing(playing_b), .done(done_b),
        .overrun(ovr_b));

    // Synchronous-read memories: A holds its own address, B is a small table.
    always @(posedge clk) begin
        rdata_a <= 16'(addr_a);
        rdata_b <= mem_b[addr_b];
    end

    typedef struct {
        logic            en;
        logic            exp_en;
        logic [AW_A-1:0] exp_addr;
        logic            exp_valid;
        logic            exp_ovr;
    } vec_t;

    vec_t vecs [16];
    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [63:0] d, prev;
    logic [3:0]  dn, pl;
    int vcount, sv;

    function automatic vec_t mk(input logic en, input logic men, input int addr,
                                input logic v, input logic o);
        vec_t r;
        r.en = en; r.exp_en = men; r.exp_addr = AW_A'(addr); r.exp_valid = v; r.exp_ovr = o;
        return r;
    endfunction

    function automatic logic [63:0] lanes(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(output logic [63:0] fd, output logic [3:0] fdn, output logic [3:0] fpl);
        int cyc;
        en_b = 1'b1;
        tick();
        en_b = 1'b0;
        cyc = 1;
        while (valid_b !== 1'b1 && cyc < 12) begin
            tick();
            cyc++;
        end
        check("frame_latency", 64'(cyc), 64'd6);
        fd  = 64'(dout_b);
        fdn = done_b;
        fpl = playing_b;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(1'b1, 1'b1, 0,     1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 4036,  1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 8072,  1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 12108, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 0,     1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 0,     1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 0,     1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 1'b1, 0,     1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 4036,  1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b1, 8072,  1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b1, 12108, 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 0,     1'b0, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 0,     1'b1, 1'b1);
        vecs[13] = mk(1'b0, 1'b0, 0,     1'b0, 1'b1);
        vecs[14] = mk(1'b0, 1'b0, 0,     1'b0, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 0,     1'b0, 1'b1);

        for (int a = 0; a < NCH * DEP_B; a++) mem_b[a] = 16'(a);
        mem_b[24] = 16'h8000;

        rst_n = 1'b0;
        en_a = 1'b0; start_a = 4'b0; stop_a = 4'b0; loop_a = 4'b0;
        en_b = 1'b0; start_b = 4'b0; stop_b = 4'b0; loop_b = 4'b0;
        repeat (2) tick();
        check("reset_a_ctl", 64'({addr_a, men_a, valid_a, playing_a, done_a, ovr_a}), 64'd0);
        check("reset_a_data", 64'(dout_a), 64'd0);
        check("reset_b_ctl", 64'({addr_b, men_b, valid_b, playing_b, done_b, ovr_b}), 64'd0);
        check("reset_b_data", 64'(dout_b), 64'd0);
        rst_n = 1'b1;
        tick();

        // Idle frame addresses, then an overrun strobe two cycles into a frame.
        for (int i = 0; i < 16; i++) begin
            en_a = vecs[i].en;
            tick();
            check($sformatf("a_v%0d_mem_en", i), 64'(men_a), 64'(vecs[i].exp_en));
            if (vecs[i].exp_en) check($sformatf("a_v%0d_addr", i), 64'(addr_a), 64'(vecs[i].exp_addr));
            check($sformatf("a_v%0d_valid", i), 64'(valid_a), 64'(vecs[i].exp_valid));
            check($sformatf("a_v%0d_overrun", i), 64'(ovr_a), 64'(vecs[i].exp_ovr));
            check($sformatf("a_v%0d_data", i), 64'(dout_a), 64'd0);
        end
        en_a = 1'b0;

        // Loop wrap on ch1.
        loop_b = 4'b0010; start_b = 4'b0010; tick(); start_b = 4'b0;
        for (int j = 0; j < 10; j++) begin
            run_frame(d, dn, pl);
            check($sformatf("loop_f%0d_data", j), d, lanes(16'd0, 16'(8 + j % 8), 16'd0, 16'd0));
            check($sformatf("loop_f%0d_playing", j), 64'(pl), 64'(4'b0010));
            check($sformatf("loop_f%0d_done", j), 64'(dn), 64'd0);
        end

        // Stop: output and status hold until the next frame start.
        prev = d;
        stop_b = 4'b0010; tick(); stop_b = 4'b0; tick();
        check("hold_after_stop", 64'(dout_b), prev);
        check("playing_before_frame", 64'(playing_b), 64'(4'b0010));
        run_frame(d, dn, pl);
        check("stopped_data", d, 64'd0);
        check("stopped_playing", 64'(pl), 64'd0);

        // One-shot on ch1.
        loop_b = 4'b0000; start_b = 4'b0010; tick(); start_b = 4'b0;
        for (int j = 0; j < 10; j++) begin
            run_frame(d, dn, pl);
            check($sformatf("oneshot_f%0d_data", j + 1), d,
                  lanes(16'd0, (j < 8) ? 16'(8 + j) : 16'd0, 16'd0, 16'd0));
            check($sformatf("oneshot_f%0d_playing", j + 1), 64'(pl), (j < 7) ? 64'(4'b0010) : 64'd0);
            check($sformatf("oneshot_f%0d_done", j + 1), 64'(dn), (j == 7) ? 64'(4'b0010) : 64'd0);
        end

        // Restart ch2 mid-play; ch0 gets start and stop together.
        loop_b = 4'b0101; start_b = 4'b0101; tick(); start_b = 4'b0;
        for (int j = 0; j < 2; j++) begin
            run_frame(d, dn, pl);
            check($sformatf("restart_pre_f%0d_data", j), d, lanes(16'(j), 16'd0, 16'(16 + j), 16'd0));
            check($sformatf("restart_pre_f%0d_playing", j), 64'(pl), 64'(4'b0101));
        end
        start_b = 4'b0101; stop_b = 4'b0001; tick(); start_b = 4'b0; stop_b = 4'b0;
        run_frame(d, dn, pl);
        check("restart_f3_data", d, lanes(16'd0, 16'd0, 16'd16, 16'd0));
        check("restart_f3_playing", 64'(pl), 64'(4'b0100));
        run_frame(d, dn, pl);
        check("restart_f4_data", d, lanes(16'd0, 16'd0, 16'd17, 16'd0));

        // A later start overrides an earlier pending stop.
        prev = d;
        stop_b = 4'b0100; tick(); stop_b = 4'b0;
        start_b = 4'b0100; tick(); start_b = 4'b0;
        check("hold_after_cmds", 64'(dout_b), prev);
        run_frame(d, dn, pl);
        check("override_data", d, lanes(16'd0, 16'd0, 16'd16, 16'd0));
        check("override_playing", 64'(pl), 64'(4'b0100));

        // Signed full-scale negative sample on ch3.
        loop_b = 4'b1100; start_b = 4'b1000; tick(); start_b = 4'b0;
        run_frame(d, dn, pl);
        check("signed_frame", d, lanes(16'd0, 16'd0, 16'd17, 16'h8000));
        sv = int'($signed(d[63:48]));
        check("signed_lane", 64'(sv), 64'(-32768));
        check("signed_playing", 64'(pl), 64'(4'b1100));

        // Reset in the middle of a frame suppresses that frame.
        en_b = 1'b1; tick(); en_b = 1'b0; tick(); tick();
        rst_n = 1'b0;
        tick();
        check("midreset_playing", 64'(playing_b), 64'd0);
        check("midreset_data", 64'(dout_b), 64'd0);
        check("midreset_ctl", 64'({men_b, valid_b, ovr_a}), 64'd0);
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_b === 1'b1) vcount++;
        end
        check("midreset_no_valid", 64'(vcount), 64'd0);
        run_frame(d, dn, pl);
        check("post_reset_data", d, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
